// File: rtl/ula_seq.sv
// Registered execute-stage ALU with Z/N/C/V flags and a start/busy/done handshake.
// Single-cycle operations finish on the accepting edge; MUL is a WIDTH-cycle shift-add loop.
module ula_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ULAControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ULAResult,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_z, r_n, r_c, r_v;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c, w_alu_v;
    logic [2*WIDTH-1:0] w_acc_sum;
    logic               w_load, w_write;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_v;

    // Single-cycle datapath, evaluated straight from the live operands.
    always_comb begin
        w_sum     = {1'b0, SrcA} + {1'b0, SrcB};
        w_diff    = {1'b0, SrcA} + {1'b0, ~SrcB} + (WIDTH+1)'(1);
        w_sh      = SrcB[SHW-1:0];
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (ULAControl)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
                w_alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_diff[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  w_alu_res = SrcA & SrcB;
            OP_OR:   w_alu_res = SrcA | SrcB;
            OP_NOR:  w_alu_res = ~(SrcA | SrcB);
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_XOR:  w_alu_res = SrcA ^ SrcB;
            OP_SLL:  w_alu_res = SrcA << w_sh;
            OP_SRL:  w_alu_res = SrcA >> w_sh;
            OP_SRA:  w_alu_res = $unsigned($signed(SrcA) >>> w_sh);
            default: w_alu_res = '0;
        endcase
    end

    // Next-state and write-enable logic; the last MUL step folds into the written result.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_write      = 1'b0;
        w_acc_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_res        = w_alu_res;
        w_c          = w_alu_c;
        w_v          = w_alu_v;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (ULAControl == OP_MUL) begin
                        w_load       = 1'b1;
                        w_state_next = S_MUL;
                    end else begin
                        w_write = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (r_count == CW'(WIDTH - 1)) begin
                    w_write      = 1'b1;
                    w_state_next = S_IDLE;
                    w_res        = w_acc_sum[WIDTH-1:0];
                    w_c          = |w_acc_sum[2*WIDTH-1:WIDTH];
                    w_v          = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_write) begin
                r_result <= w_res;
                r_z      <= (w_res == '0);
                r_n      <= w_res[WIDTH-1];
                r_c      <= w_c;
                r_v      <= w_v;
            end
            if (w_load) begin
                r_mcand  <= {{WIDTH{1'b0}}, SrcA};
                r_mplier <= SrcB;
                r_acc    <= '0;
                r_count  <= '0;
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CW'(1);
            end
        end
    end

    assign busy      = (r_state == S_MUL);
    assign done      = r_done;
    assign ULAResult = r_result;
    assign Z         = r_z;
    assign N         = r_n;
    assign C         = r_c;
    assign V         = r_v;
endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (WIDTH=8): directed vector table, handshake/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_ula_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] SrcA = '0;
    logic [7:0] SrcB = '0;
    logic [3:0] ULAControl = '0;
    logic       busy, done, Z, N, C, V;
    logic [7:0] ULAResult;

    int checks = 0;
    int errors = 0;

    ula_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .SrcA(SrcA), .SrcB(SrcB),
        .ULAControl(ULAControl), .busy(busy), .done(done), .ULAResult(ULAResult),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;   // {Z,N,C,V}
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the operation rules using plain integer arithmetic.
    function automatic vec_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        vec_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = $signed(a);
        int sb = $signed(b);
        int k  = ub % 8;
        int r  = 0;
        int s;
        logic c = 1'b0;
        logic v = 1'b0;
        case (op)
            4'd0:  begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            4'd1:  begin r = ua - ub; c = (ua >= ub); s = sa - sb; v = (s > 127) || (s < -128); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ~(ua | ub);
            4'd5:  r = (sa < sb) ? 1 : 0;
            4'd6:  r = (ua < ub) ? 1 : 0;
            4'd7:  r = ua ^ ub;
            4'd8:  r = ua << k;
            4'd9:  r = ua >> k;
            4'd10: r = sa >>> k;
            4'd11: begin r = ua * ub; c = (r > 255); end
            default: r = 0;
        endcase
        r = r & 255;
        e.op = op; e.a = a; e.b = b;
        e.r  = 8'(r);
        e.f  = {(r == 0), (r >= 128), c, v};
        return e;
    endfunction

    // Issue one request, wait (bounded) for done, check result, flags, latency and pulse width.
    task automatic run_check(input string name, input vec_t e);
        int edges = 0;
        int busy_cnt = 0;
        int exp_lat = (e.op == 4'd11) ? 8 : 0;
        @(negedge clk);
        ULAControl = e.op; SrcA = e.a; SrcB = e.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        chk({name, "_done_seen"}, int'(done), 1);
        chk({name, "_latency"}, edges, exp_lat);
        chk({name, "_busy_cycles"}, busy_cnt, exp_lat);
        chk({name, "_result"}, int'(ULAResult), int'(e.r));
        chk({name, "_flags"}, int'({Z, N, C, V}), int'(e.f));
        $display("op=%0d a=0x%02h b=0x%02h -> res=0x%02h ZNCV=%04b lat=%0d", e.op, e.a, e.b, ULAResult, {Z, N, C, V}, edges);
        @(negedge clk);
        chk({name, "_done_single"}, int'(done), 0);
        chk({name, "_hold"}, int'(ULAResult), int'(e.r));
    endtask

    vec_t tbl[$];
    vec_t e;

    initial begin
        tbl.push_back('{4'h0, 8'h7F, 8'h01, 8'h80, 4'b0101});
        tbl.push_back('{4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010});
        tbl.push_back('{4'h1, 8'h05, 8'h05, 8'h00, 4'b1010});
        tbl.push_back('{4'h1, 8'h03, 8'h05, 8'hFE, 4'b0100});
        tbl.push_back('{4'h5, 8'hFF, 8'h01, 8'h01, 4'b0000});
        tbl.push_back('{4'h6, 8'hFF, 8'h01, 8'h00, 4'b1000});
        tbl.push_back('{4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0000});
        tbl.push_back('{4'h3, 8'hF0, 8'h3C, 8'hFC, 4'b0100});
        tbl.push_back('{4'h4, 8'hF0, 8'h0F, 8'h00, 4'b1000});
        tbl.push_back('{4'h7, 8'hAA, 8'h55, 8'hFF, 4'b0100});
        tbl.push_back('{4'hA, 8'h80, 8'h03, 8'hF0, 4'b0100});
        tbl.push_back('{4'h9, 8'h80, 8'h03, 8'h10, 4'b0000});
        tbl.push_back('{4'h8, 8'h81, 8'h09, 8'h02, 4'b0000});
        tbl.push_back('{4'hF, 8'h12, 8'h34, 8'h00, 4'b1000});
        tbl.push_back('{4'hB, 8'h0D, 8'h0B, 8'h8F, 4'b0100});
        tbl.push_back('{4'hB, 8'h10, 8'h10, 8'h00, 4'b1010});
        tbl.push_back('{4'hB, 8'hFF, 8'hFF, 8'h01, 4'b0010});

        // Reset state
        #12;
        chk("reset_outputs", int'({busy, done, ULAResult, Z, N, C, V}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_check($sformatf("vec%0d", i), tbl[i]);

        // Back-to-back single-cycle requests: done high every cycle
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ULAControl = 4'h0; SrcA = 8'(i * 16); SrcB = 8'(i + 1); start = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b%0d_done", i), int'(done), 1);
            chk($sformatf("b2b%0d_result", i), int'(ULAResult), i * 17 + 1);
            $display("b2b %0d: done=%0b res=0x%02h", i, done, ULAResult);
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b_done_low", int'(done), 0);

        // Handshake: start held with ADD and churning operands during a MUL
        begin
            int dones = 0;
            int guard = 0;
            ULAControl = 4'hB; SrcA = 8'd13; SrcB = 8'd11; start = 1'b1;
            @(negedge clk);
            while (busy && guard < 40) begin
                ULAControl = 4'h0; SrcA = 8'($urandom); SrcB = 8'($urandom); start = 1'b1;
                if (done) dones++;
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            chk("hs_busy_cycles", guard, 8);
            for (int i = 0; i < 5; i++) begin
                if (done) dones++;
                @(negedge clk);
            end
            chk("hs_done_count", dones, 1);
            chk("hs_result", int'(ULAResult), 8'h8F);
            chk("hs_flags", int'({Z, N, C, V}), 4'b0100);
            $display("handshake: dones=%0d res=0x%02h", dones, ULAResult);
        end

        // Asynchronous reset in the 4th MUL cycle
        begin
            int dones = 0;
            ULAControl = 4'hB; SrcA = 8'hFF; SrcB = 8'hFF; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            chk("rst_pre_busy", int'(busy), 1);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_async_outputs", int'({busy, done, ULAResult, Z, N, C, V}), 0);
            $display("async reset: busy=%0b done=%0b res=0x%02h", busy, done, ULAResult);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (done) dones++;
                @(negedge clk);
            end
            chk("rst_no_done", dones, 0);
            chk("rst_result_zero", int'(ULAResult), 0);
            e = '{4'h0, 8'h02, 8'h03, 8'h05, 4'b0000};
            run_check("rst_add", e);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 120; i++) begin
            e = model(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            run_check($sformatf("rnd%0d", i), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, registered successor of the processor's 8-bit ULA. It extends the operation set with XOR, OR, unsigned compare, three shifts and a multi-cycle shift-add multiplier, and adds a full Z/N/C/V flag set. A start/busy/done handshake lets the datapath control unit stall on multi-cycle operations. It sits in the execute stage between the register-file read ports and the write-back mux.

## Interface
- WIDTH, 8, operand/result width in bits (>= 4)
- SHW, $clog2(WIDTH), derived; shift-amount width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- SrcA  in  WIDTH  operand A
- SrcB  in  WIDTH  operand B; shifts use SrcB[SHW-1:0] as the shift amount
- ULAControl  in  4  opcode
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse; result and flags updated this cycle
- ULAResult  out  WIDTH  registered result
- Z, N, C, V  out  1 each  registered zero, negative, carry and overflow flags

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB (A + ~B + 1)
  - 0010 AND
  - 0011 OR
  - 0100 NOR
  - 0101 SLT signed (result 1/0)
  - 0110 SLTU unsigned
  - 0111 XOR
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - 1011 MUL (unsigned, low WIDTH bits)
  - 1100-1111 undefined: result 0
- Operands and opcode are latched on the accepting edge. Input changes after that edge have no effect on the operation in progress.
- Flags:
  - Z = (result == 0)
  - N = result[WIDTH-1]
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow
  - SUB: C = carry out of A + ~B + 1, so 1 means A >= B unsigned; V = signed overflow
  - MUL: C = 1 if the upper WIDTH bits of the 2*WIDTH-bit product are nonzero; V = 0
  - All other opcodes: C = 0, V = 0
- ULAResult and the flags change only on a done edge. They hold otherwise.
- FSM states:
  - IDLE: busy=0. start with a non-MUL opcode writes result and flags, pulses done, and stays in IDLE. start with MUL loads the multiplicand, multiplier, a 2*WIDTH-bit accumulator and count=0, then goes to MUL.
  - MUL: busy=1. Each edge: if multiplier[0] is set, add the shifted multiplicand to the accumulator; shift the multiplier right and the multiplicand left; count++. On the edge where count reaches WIDTH, write result and flags, pulse done, return to IDLE.
- start while busy=1 is ignored and not queued.
- Reset (asynchronous, any state) forces IDLE and sets busy, done, ULAResult, Z, N, C and V to 0. An aborted multiply produces no done.

## Timing
- Non-MUL: start sampled at edge E0; done=1 and new ULAResult/flags are visible during the cycle after E0.
- Back-to-back non-MUL requests are accepted every cycle, so done can be high in consecutive cycles.
- MUL: start sampled at E0; busy=1 from E0 until EWIDTH; done=1 and result valid after EWIDTH (latency WIDTH cycles).
- A new start may be sampled on the same edge that busy falls, i.e. the first edge where busy=0 is sampled.
- done is never high for more than one cycle per accepted request.
- Shift amount is taken modulo WIDTH, since only SrcB[SHW-1:0] is used.

## Test plan
- ADD, WIDTH=8: 0x7F + 0x01 -> ULAResult=0x80, N=1, V=1, C=0, Z=0, done one cycle after start. Also 0xFF + 0x01 -> 0x00, Z=1, C=1, V=0.
- SUB/compare:
  - 0x05 - 0x05 -> 0x00, Z=1, C=1
  - 0x03 - 0x05 -> 0xFE, N=1, C=0
  - SLT 0xFF vs 0x01 -> 0x01
  - SLTU 0xFF vs 0x01 -> 0x00
- MUL:
  - 13 × 11 -> 0x8F, C=0; busy high for exactly 8 cycles, single done pulse
  - 0x10 × 0x10 -> 0x00, Z=1, C=1
  - 0xFF × 0xFF -> 0x01, C=1
- Handshake: during a MUL, assert start with an ADD and change SrcA/SrcB every cycle -> MUL result unaffected, ADD not executed, exactly one done.
- Reset: drop rst_n at the 4th MUL cycle -> all outputs 0 immediately with no clock edge, no done; after release, ADD 2 + 3 -> 0x05 one cycle after start.
- Shifts and undefined opcodes:
  - SRA 0x80 by 3 -> 0xF0, N=1
  - SRL 0x80 by 3 -> 0x10
  - SLL 0x81 by 9 (modulo 8, i.e. 1) -> 0x02
  - Opcode 1111 -> 0x00, Z=1, C=0, V=0, done in one cycle
